// File: rtl/cpu64_l2_dir_lookup.sv
// L2 coherence directory lookup: accepts one request, reads the set, updates the entry and returns probes.
// Optional power-up sweep that zeroes every directory entry: define L2_DIR_INIT_SWEEP_EN.
module cpu64_l2_dir_lookup #(
  parameter int unsigned SETS  = 256,
  parameter int unsigned WAYS  = 16,
  parameter int unsigned CORES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [$clog2(SETS)-1:0]           req_set_i,
  input  logic [$clog2(WAYS)-1:0]           req_way_i,
  input  logic                              req_hit_i,
  input  logic [$clog2(CORES)-1:0]          req_core_i,
  input  logic [1:0]                        req_op_i,
  output logic [$clog2(SETS)-1:0]           dir_rd_set_o,
  input  logic [WAYS-1:0]                   dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0]             dir_rd_sharers_i,
  input  logic [WAYS-1:0]                   dir_rd_owner_valid_i,
  input  logic [WAYS*$clog2(CORES)-1:0]     dir_rd_owner_id_i,
  input  logic [WAYS-1:0]                   dir_rd_dirty_i,
  output logic                              dir_we_o,
  output logic [$clog2(SETS)-1:0]           dir_wr_set_o,
  output logic [$clog2(WAYS)-1:0]           dir_wr_way_o,
  output logic                              dir_wr_valid_o,
  output logic                              dir_wr_owner_valid_o,
  output logic                              dir_wr_dirty_o,
  output logic [CORES-1:0]                  dir_wr_sharers_o,
  output logic [$clog2(CORES)-1:0]          dir_wr_owner_id_o,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [$clog2(CORES)-1:0]          rsp_core_o,
  output logic [CORES-1:0]                  rsp_probe_mask_o,
  output logic                              rsp_probe_inv_o,
  output logic                              rsp_need_mem_o,
  output logic                              rsp_writeback_o,
  output logic                              init_done_o
);
  localparam int unsigned SW = $clog2(SETS);
  localparam int unsigned WW = $clog2(WAYS);
  localparam int unsigned CW = $clog2(CORES);
  localparam int unsigned IW = SW + WW;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOK, S_RESP} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] sweep_idx;
  logic          sweep_last;
  logic          init_done_q;

`ifdef L2_DIR_INIT_SWEEP_EN
  localparam state_t RST_STATE = S_INIT;
  // Sweep index: way in the low bits so ways advance fastest within a set.
  always_ff @(posedge clk) begin
    if (rst)                 sweep_idx <= '0;
    else if (state == S_INIT) sweep_idx <= sweep_idx + IW'(1);
  end
  assign sweep_last = (sweep_idx == IW'(SETS * WAYS - 1));
`else
  localparam state_t RST_STATE = S_IDLE;
  assign sweep_idx  = '0;
  assign sweep_last = 1'b1;
`endif

  logic [SW-1:0] set_q;
  logic [WW-1:0] way_q;
  logic          hit_q;
  logic [CW-1:0] core_q;
  logic [1:0]    op_q;

  // Current entry and computed update/response for the latched request.
  logic             cur_valid, cur_ov, cur_dty, hit_e, own_is_core, lk_cand, lk_we;
  logic [CORES-1:0] cur_sh, core_bit, own_bit, lk_probe;
  logic [CW-1:0]    cur_oid;
  logic             lk_inv, lk_mem, lk_wb;
  logic             n_valid, n_ov, n_dty;
  logic [CORES-1:0] n_sh;
  logic [CW-1:0]    n_oid;

  always_comb begin
    cur_valid   = dir_rd_valid_i[way_q];
    cur_sh      = dir_rd_sharers_i[way_q*CORES +: CORES];
    cur_ov      = dir_rd_owner_valid_i[way_q];
    cur_oid     = cur_ov ? dir_rd_owner_id_i[way_q*CW +: CW] : '0;
    cur_dty     = dir_rd_dirty_i[way_q];
    hit_e       = hit_q & cur_valid;
    core_bit    = CORES'(1) << core_q;
    own_bit     = cur_ov ? (CORES'(1) << cur_oid) : '0;
    own_is_core = cur_ov && (cur_oid == core_q);
    lk_probe = '0;
    lk_inv   = 1'b0;
    lk_mem   = 1'b0;
    lk_wb    = 1'b0;
    lk_cand  = 1'b0;
    n_valid  = cur_valid;
    n_sh     = cur_sh;
    n_ov     = cur_ov;
    n_oid    = cur_oid;
    n_dty    = cur_dty;
    unique case (op_q)
      2'd0: begin
        if (!hit_e) begin
          lk_mem = 1'b1; lk_cand = 1'b1;
          n_valid = 1'b1; n_sh = core_bit; n_ov = 1'b0; n_dty = 1'b0;
        end else if (cur_ov && !own_is_core) begin
          lk_probe = own_bit; lk_wb = cur_dty; lk_cand = 1'b1;
          n_sh = own_bit | core_bit; n_ov = 1'b0; n_dty = 1'b0;
        end else if (!cur_ov) begin
          lk_cand = 1'b1; n_sh = cur_sh | core_bit;
        end
      end
      2'd1: begin
        lk_probe = (hit_e ? (cur_sh | own_bit) : '0) & ~core_bit;
        lk_inv   = 1'b1;
        lk_wb    = hit_e & cur_dty & !own_is_core;
        lk_mem   = !hit_e;
        lk_cand  = 1'b1;
        n_valid = 1'b1; n_ov = 1'b1; n_oid = core_q; n_sh = '0; n_dty = 1'b1;
      end
      2'd2: begin
        if (hit_e && own_is_core) begin
          lk_wb = 1'b1; lk_cand = 1'b1;
          n_valid = 1'b1; n_ov = 1'b0; n_sh = '0; n_dty = 1'b0;
        end
      end
      default: begin
        if (hit_e) begin
          lk_probe = cur_sh | own_bit; lk_inv = 1'b1; lk_wb = cur_dty; lk_cand = 1'b1;
          n_valid = 1'b0; n_ov = 1'b0; n_sh = '0; n_dty = 1'b0;
        end
      end
    endcase
    if (!n_ov) n_oid = '0;
    // A miss fill always writes; a hit writes only when the entry actually changes.
    lk_we = lk_cand && (!hit_e ||
            ({n_valid, n_sh, n_ov, n_oid, n_dty} != {cur_valid, cur_sh, cur_ov, cur_oid, cur_dty}));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  if (sweep_last)  state_nxt = S_IDLE;
      S_IDLE:  if (req_valid_i) state_nxt = S_LOOK;
      S_LOOK:                   state_nxt = S_RESP;
      S_RESP:  if (rsp_ready_i) state_nxt = S_IDLE;
      default:                  state_nxt = RST_STATE;
    endcase
  end

  always_comb begin
    req_ready_o          = (state == S_IDLE) && !rst;
    rsp_valid_o          = (state == S_RESP) && !rst;
    init_done_o          = init_done_q && !rst;
    dir_rd_set_o         = set_q;
    dir_we_o             = 1'b0;
    dir_wr_set_o         = set_q;
    dir_wr_way_o         = way_q;
    dir_wr_valid_o       = n_valid;
    dir_wr_owner_valid_o = n_ov;
    dir_wr_dirty_o       = n_dty;
    dir_wr_sharers_o     = n_sh;
    dir_wr_owner_id_o    = n_oid;
    if (state == S_INIT) begin
      dir_we_o             = 1'b1;
      dir_wr_set_o         = sweep_idx[WW +: SW];
      dir_wr_way_o         = sweep_idx[WW-1:0];
      dir_wr_valid_o       = 1'b0;
      dir_wr_owner_valid_o = 1'b0;
      dir_wr_dirty_o       = 1'b0;
      dir_wr_sharers_o     = '0;
      dir_wr_owner_id_o    = '0;
    end else if (state == S_LOOK) begin
      dir_we_o = lk_we;
    end
    // A request caught by reset must never reach the directory.
    if (rst) dir_we_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_q            <= '0;
      way_q            <= '0;
      hit_q            <= 1'b0;
      core_q           <= '0;
      op_q             <= '0;
      rsp_core_o       <= '0;
      rsp_probe_mask_o <= '0;
      rsp_probe_inv_o  <= 1'b0;
      rsp_need_mem_o   <= 1'b0;
      rsp_writeback_o  <= 1'b0;
      init_done_q      <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid_i) begin
        set_q  <= req_set_i;
        way_q  <= req_way_i;
        hit_q  <= req_hit_i;
        core_q <= req_core_i;
        op_q   <= req_op_i;
      end
      if (state == S_LOOK) begin
        rsp_core_o       <= core_q;
        rsp_probe_mask_o <= lk_probe;
        rsp_probe_inv_o  <= lk_inv;
        rsp_need_mem_o   <= lk_mem;
        rsp_writeback_o  <= lk_wb;
      end
`ifdef L2_DIR_INIT_SWEEP_EN
      if (state == S_INIT && sweep_last) init_done_q <= 1'b1;
`else
      init_done_q <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_cpu64_l2_dir_lookup.sv
// Bench for cpu64_l2_dir_lookup: directory memory model, directed requests, response scoreboard.
module tb_cpu64_l2_dir_lookup;
  localparam int unsigned SETS  = 256;
  localparam int unsigned WAYS  = 16;
  localparam int unsigned CORES = 4;
  localparam int unsigned SW = $clog2(SETS);
  localparam int unsigned WW = $clog2(WAYS);
  localparam int unsigned CW = $clog2(CORES);

  typedef struct packed {
    logic [CW-1:0]    core;
    logic [CORES-1:0] probe;
    logic             inv;
    logic             mem;
    logic             wb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_hit;
  logic [SW-1:0] req_set;
  logic [WW-1:0] req_way;
  logic [CW-1:0] req_core;
  logic [1:0]    req_op;
  logic [SW-1:0] rd_set;
  logic [WAYS-1:0] rd_valid, rd_ov, rd_dty;
  logic [WAYS*CORES-1:0] rd_sh;
  logic [WAYS*CW-1:0]    rd_oid;
  logic we, wr_valid, wr_ov, wr_dty;
  logic [SW-1:0] wr_set;
  logic [WW-1:0] wr_way;
  logic [CORES-1:0] wr_sh;
  logic [CW-1:0] wr_oid;
  logic rsp_valid, rsp_ready, rsp_inv, rsp_mem, rsp_wb, init_done;
  logic [CW-1:0] rsp_core;
  logic [CORES-1:0] rsp_probe;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  exp_t sbq[$];

  logic             m_v   [SETS][WAYS] = '{default: '0};
  logic [CORES-1:0] m_sh  [SETS][WAYS] = '{default: '0};
  logic             m_ov  [SETS][WAYS] = '{default: '0};
  logic [CW-1:0]    m_oid [SETS][WAYS] = '{default: '0};
  logic             m_d   [SETS][WAYS] = '{default: '0};

  logic pl_en = 1'b0;
  logic [SW-1:0] pl_set;
  logic [WW-1:0] pl_way;
  logic pl_v, pl_ov, pl_d;
  logic [CORES-1:0] pl_sh;
  logic [CW-1:0] pl_oid;

  always #5 clk = ~clk;

  cpu64_l2_dir_lookup #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_set_i(req_set), .req_way_i(req_way),
    .req_hit_i(req_hit), .req_core_i(req_core), .req_op_i(req_op),
    .dir_rd_set_o(rd_set), .dir_rd_valid_i(rd_valid), .dir_rd_sharers_i(rd_sh),
    .dir_rd_owner_valid_i(rd_ov), .dir_rd_owner_id_i(rd_oid), .dir_rd_dirty_i(rd_dty),
    .dir_we_o(we), .dir_wr_set_o(wr_set), .dir_wr_way_o(wr_way), .dir_wr_valid_o(wr_valid),
    .dir_wr_owner_valid_o(wr_ov), .dir_wr_dirty_o(wr_dty), .dir_wr_sharers_o(wr_sh),
    .dir_wr_owner_id_o(wr_oid),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_core_o(rsp_core),
    .rsp_probe_mask_o(rsp_probe), .rsp_probe_inv_o(rsp_inv), .rsp_need_mem_o(rsp_mem),
    .rsp_writeback_o(rsp_wb), .init_done_o(init_done)
  );

  // Directory storage: combinational read on the DUT's read set.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_valid[w]             = m_v[rd_set][w];
      rd_sh[w*CORES +: CORES] = m_sh[rd_set][w];
      rd_ov[w]                = m_ov[rd_set][w];
      rd_oid[w*CW +: CW]      = m_oid[rd_set][w];
      rd_dty[w]               = m_d[rd_set][w];
    end
  end

`ifdef L2_DIR_INIT_SWEEP_EN
  int sw_exp = 0;
  int sw_err = 0;
`endif

  always @(posedge clk) begin
    if (we) begin
      m_v[wr_set][wr_way]   <= wr_valid;
      m_sh[wr_set][wr_way]  <= wr_sh;
      m_ov[wr_set][wr_way]  <= wr_ov;
      m_oid[wr_set][wr_way] <= wr_oid;
      m_d[wr_set][wr_way]   <= wr_dty;
      wr_cnt <= wr_cnt + 1;
    end else if (pl_en) begin
      m_v[pl_set][pl_way]   <= pl_v;
      m_sh[pl_set][pl_way]  <= pl_sh;
      m_ov[pl_set][pl_way]  <= pl_ov;
      m_oid[pl_set][pl_way] <= pl_oid;
      m_d[pl_set][pl_way]   <= pl_d;
    end
`ifdef L2_DIR_INIT_SWEEP_EN
    if (rst) sw_exp <= 0;
    else if (we && !init_done) begin
      if (int'({wr_set, wr_way}) != sw_exp) sw_err <= sw_err + 1;
      sw_exp <= sw_exp + 1;
    end
`endif
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // Monitor: every accepted response is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) check("unexpected_rsp", 32'(1), 32'(0));
      else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp", 32'({rsp_core, rsp_probe, rsp_inv, rsp_mem, rsp_wb}), 32'(e));
      end
    end
  end

  task automatic preload(input logic [SW-1:0] s, input logic [WW-1:0] w, input logic v,
                         input logic [CORES-1:0] sh, input logic ov, input logic [CW-1:0] oid,
                         input logic d);
    pl_set = s; pl_way = w; pl_v = v; pl_sh = sh; pl_ov = ov; pl_oid = oid; pl_d = d;
    pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [SW-1:0] s, input logic [WW-1:0] w, input logic h,
                       input logic [CW-1:0] c, input logic [1:0] op, input exp_t e,
                       input bit expect_rsp);
    int n;
    if (expect_rsp) sbq.push_back(e);
    req_set = s; req_way = w; req_hit = h; req_core = c; req_op = op;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("rsp_timeout", 32'(sbq.size()), 32'(0));
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < int'(SETS * WAYS) + 20) begin @(posedge clk); #1; n++; end
    check("init_done", 32'(init_done), 32'(1));
    check("ready_after_init", 32'(req_ready), 32'(1));
  endtask

  task automatic chk_entry(input string name, input logic [SW-1:0] s, input logic [WW-1:0] w,
                           input logic v, input logic [CORES-1:0] sh, input logic ov,
                           input logic [CW-1:0] oid, input logic d);
    check(name, 32'({m_v[s][w], m_sh[s][w], m_ov[s][w], m_oid[s][w], m_d[s][w]}),
          32'({v, sh, ov, oid, d}));
  endtask

  initial begin
    int w0;
    rst = 1'b1; req_valid = 1'b0; req_set = '0; req_way = '0; req_hit = 1'b0;
    req_core = '0; req_op = '0; rsp_ready = 1'b1;
    pl_set = '0; pl_way = '0; pl_v = 1'b0; pl_sh = '0; pl_ov = 1'b0; pl_oid = '0; pl_d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_we", 32'(we), 32'(0));
    check("rst_init_done", 32'(init_done), 32'(0));
    check("rst_rsp_fields", 32'({rsp_core, rsp_probe, rsp_inv, rsp_mem, rsp_wb}), 32'(0));
    rst = 1'b0;
    wait_init();
`ifdef L2_DIR_INIT_SWEEP_EN
    check("sweep_count", 32'(wr_cnt), 32'(SETS * WAYS));
    check("sweep_order", 32'(sw_err), 32'(0));
`endif

    // GetS miss fills the victim; response two cycles after accept.
    issue(8'd5, 4'd3, 1'b0, 2'd2, 2'd0, '{core: 2'd2, probe: 4'b0000, inv: 1'b0, mem: 1'b1, wb: 1'b0}, 1'b1);
    check("lat_look", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    check("lat_resp", 32'(rsp_valid), 32'(1));
    wait_rsp();
    chk_entry("gets_miss_entry", 8'd5, 4'd3, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);

    // GetS against a dirty remote owner downgrades it.
    preload(8'd7, 4'd1, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1);
    issue(8'd7, 4'd1, 1'b1, 2'd0, 2'd0, '{core: 2'd0, probe: 4'b0010, inv: 1'b0, mem: 1'b0, wb: 1'b1}, 1'b1);
    wait_rsp();
    chk_entry("gets_owner_entry", 8'd7, 4'd1, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b0);

    // GetM invalidates every other sharer.
    preload(8'd9, 4'd0, 1'b1, 4'b1011, 1'b0, 2'd0, 1'b0);
    issue(8'd9, 4'd0, 1'b1, 2'd0, 2'd1, '{core: 2'd0, probe: 4'b1010, inv: 1'b1, mem: 1'b0, wb: 1'b0}, 1'b1);
    wait_rsp();
    chk_entry("getm_entry", 8'd9, 4'd0, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1);

    // Back-pressure: response held steady and no new request accepted.
    preload(8'd10, 4'd2, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    rsp_ready = 1'b0;
    issue(8'd10, 4'd2, 1'b1, 2'd2, 2'd0, '{core: 2'd2, probe: 4'b0000, inv: 1'b0, mem: 1'b0, wb: 1'b0}, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'(1));
      check("stall_fields", 32'({rsp_core, rsp_probe, rsp_inv, rsp_mem, rsp_wb}), 32'(9'b10_0000_000));
      check("stall_ready", 32'(req_ready), 32'(0));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_rsp();
    chk_entry("gets_share_entry", 8'd10, 4'd2, 1'b1, 4'b0101, 1'b0, 2'd0, 1'b0);

    // Stale PutM from a non-owner: no write, no flags.
    preload(8'd11, 4'd4, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1);
    w0 = wr_cnt;
    issue(8'd11, 4'd4, 1'b1, 2'd3, 2'd2, '{core: 2'd3, probe: 4'b0000, inv: 1'b0, mem: 1'b0, wb: 1'b0}, 1'b1);
    wait_rsp();
    check("stale_putm_nowrite", 32'(wr_cnt - w0), 32'(0));
    issue(8'd11, 4'd4, 1'b1, 2'd1, 2'd2, '{core: 2'd1, probe: 4'b0000, inv: 1'b0, mem: 1'b0, wb: 1'b1}, 1'b1);
    wait_rsp();
    chk_entry("putm_entry", 8'd11, 4'd4, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Evictions: shared line, dirty owned line, then a miss.
    preload(8'd12, 4'd5, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b0);
    issue(8'd12, 4'd5, 1'b1, 2'd0, 2'd3, '{core: 2'd0, probe: 4'b0110, inv: 1'b1, mem: 1'b0, wb: 1'b0}, 1'b1);
    wait_rsp();
    chk_entry("evict_shared_entry", 8'd12, 4'd5, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    preload(8'd12, 4'd6, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1);
    issue(8'd12, 4'd6, 1'b1, 2'd0, 2'd3, '{core: 2'd0, probe: 4'b1000, inv: 1'b1, mem: 1'b0, wb: 1'b1}, 1'b1);
    wait_rsp();
    chk_entry("evict_owned_entry", 8'd12, 4'd6, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    w0 = wr_cnt;
    issue(8'd12, 4'd7, 1'b0, 2'd0, 2'd3, '{core: 2'd0, probe: 4'b0000, inv: 1'b0, mem: 1'b0, wb: 1'b0}, 1'b1);
    wait_rsp();
    check("evict_miss_nowrite", 32'(wr_cnt - w0), 32'(0));

    // GetM miss, then GetS by the new owner leaves the entry untouched.
    issue(8'd13, 4'd0, 1'b0, 2'd1, 2'd1, '{core: 2'd1, probe: 4'b0000, inv: 1'b1, mem: 1'b1, wb: 1'b0}, 1'b1);
    wait_rsp();
    chk_entry("getm_miss_entry", 8'd13, 4'd0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1);
    w0 = wr_cnt;
    issue(8'd13, 4'd0, 1'b1, 2'd1, 2'd0, '{core: 2'd1, probe: 4'b0000, inv: 1'b0, mem: 1'b0, wb: 1'b0}, 1'b1);
    wait_rsp();
    check("owner_gets_nowrite", 32'(wr_cnt - w0), 32'(0));

    // Reset during LOOK discards the request.
    w0 = wr_cnt;
    issue(8'd14, 4'd0, 1'b0, 2'd2, 2'd0, '{core: 2'd0, probe: 4'b0000, inv: 1'b0, mem: 1'b0, wb: 1'b0}, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_look_we", 32'(we), 32'(0));
    repeat (2) begin @(posedge clk); #1; end
    check("rst_look_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_look_nowrite", 32'(wr_cnt - w0), 32'(0));
    rst = 1'b0;
    #1;
`ifdef L2_DIR_INIT_SWEEP_EN
    check("restart_in_init", 32'(req_ready), 32'(0));
`endif
    wait_init();
    chk_entry("rst_look_entry", 8'd14, 4'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    check("sb_empty", 32'(sbq.size()), 32'(0));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
